mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter W_CPU, default 32, data and address width.
REQ-002 Parameter LAT, default 2, memory read latency in cycles from issue to valid m_rdata; legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: state clears on a rising clk edge while rst=0.
REQ-005 i_req  input  1  instruction-fetch request.
REQ-006 i_addr  input  W_CPU  fetch address.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_done  output  1  one-cycle pulse; i_rdata valid.
REQ-009 i_rdata  output  W_CPU  fetched word, registered.
REQ-010 d_req  input  1  data load/store request.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  W_CPU  data address.
REQ-013 d_wdata  input  W_CPU  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_done  output  1  one-cycle pulse; load data valid or store complete.
REQ-016 d_rdata  output  W_CPU  loaded word, registered.
REQ-017 m_en  output  1  memory access strobe, high only in the issue cycle.
REQ-018 m_we  output  1  memory write enable.
REQ-019 m_addr  output  W_CPU  memory address.
REQ-020 m_wdata  output  W_CPU  memory write data.
REQ-021 m_rdata  input  W_CPU  memory read data.
REQ-022 busy  output  1  high while an access is outstanding (WAIT state).
REQ-023 owner  output  1  0 = fetch, 1 = data; identifies the current or last granted port.

Function
REQ-024 The state machine has two states: IDLE and WAIT.
REQ-025 IDLE with no request: hold; all grants, m_en and m_we are 0.
REQ-026 IDLE with exactly one request: that port wins.
REQ-027 IDLE with both requests: the port not granted last wins (round-robin); owner is 0 after reset, so the first tie goes to fetch.
REQ-028 Issue cycle (IDLE with a winner) actions:
- winner gnt=1 and m_en=1;
- m_addr, m_we and m_wdata are driven combinationally from the winner (m_we=0 for fetch);
- the winner's fields are latched, owner is updated and the state goes to WAIT with counter=1.
REQ-029 WAIT: gnt=0 on both ports and m_en=0; m_addr, m_we and m_wdata hold the latched values.
REQ-030 Requests arriving during WAIT are ignored until IDLE.
REQ-031 WAIT counter: increments each cycle; when counter==LAT, m_rdata is captured into the owner's rdata register (loads and fetches only), that port's done pulses high next cycle, and the state returns to IDLE.
REQ-032 Timing: issue at cycle t gives done at t+LAT+1; the done cycle is an IDLE cycle, so a new grant may occur in it (occupancy LAT+1 cycles per access).
REQ-033 A store leaves d_rdata unchanged.
REQ-034 An unused port's rdata is never modified.
REQ-035 A requester may drop req after its gnt; req held high after done is treated as a new request.
REQ-036 Address, write-enable and data inputs are sampled only in the issue cycle; later changes have no effect on the access in flight.
REQ-037 Counter width is 4 bits; it never wraps for legal LAT.

Reset
REQ-038 While rst=0 at a clock edge, the next state is:
- state IDLE, counter 0, owner 0;
- i_rdata and d_rdata 0;
- done pulses, busy, m_en, m_we and grants all 0;
- m_addr and m_wdata 0.
REQ-039 Reset during WAIT aborts the access; no done pulse is produced for it, and normal arbitration resumes the first cycle after rst returns to 1.

Verification
REQ-040 LAT=2; after reset, i_req=1 with i_addr=0x00000040 at cycle 1 -> at cycle 1 i_gnt=1, m_en=1, m_addr=0x40; memory drives m_rdata=0x2002000A at cycle 3 -> at cycle 4 i_done=1 and i_rdata=0x2002000A.
REQ-041 Both ports request continuously from reset -> grants go to fetch, data, fetch, data, with issue cycles spaced 3 apart and owner toggling 0,1,0,1.
REQ-042 d_req=1, d_we=1, d_addr=0x00001000, d_wdata=0xDEADBEEF -> in the issue cycle m_we=1, m_addr=0x1000, m_wdata=0xDEADBEEF, held through WAIT; d_done pulses 3 cycles later and d_rdata is unchanged.
REQ-043 d_req is raised during a fetch WAIT -> d_gnt stays 0 until the cycle i_done=1, then d_gnt=1 in that same cycle.
REQ-044 rst=0 asserted one cycle after a fetch issue -> no i_done; busy=0, all outputs 0; a later request is granted normally.
REQ-045 LAT=1; a single load -> d_done at issue+2 with the captured m_rdata value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (i_*) and a data load/store port (d_*).
//
// Each access occupies the memory for LAT+1 cycles:
//   - issue cycle: grant and m_en are combinational from the request
//   - LAT wait cycles
//   - done pulse in the following IDLE cycle, which can also issue again
// On a simultaneous request the port not granted last wins. The first tie
// after reset goes to fetch.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   i_req, i_addr             fetch request in
//   i_gnt, i_done, i_rdata    fetch request out
//   d_req, d_we, d_addr,      data request in
//   d_wdata
//   d_gnt, d_done, d_rdata    data request out
//   m_en, m_we, m_addr,       memory side; m_rdata is captured LAT cycles
//   m_wdata, m_rdata          after issue
//   busy                      an access is outstanding
//   owner                     current or last granted port (0 fetch, 1 data)
module mem_arbiter #(
  parameter int unsigned W_CPU = 32,
  parameter int unsigned LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [W_CPU-1:0] i_addr,
  output logic             i_gnt,
  output logic             i_done,
  output logic [W_CPU-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [W_CPU-1:0] d_addr,
  input  logic [W_CPU-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_done,
  output logic [W_CPU-1:0] d_rdata,
  output logic             m_en,
  output logic             m_we,
  output logic [W_CPU-1:0] m_addr,
  output logic [W_CPU-1:0] m_wdata,
  input  logic [W_CPU-1:0] m_rdata,
  output logic             busy,
  output logic             owner
);

  localparam logic [3:0] LatC = 4'(LAT);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             owner_q;
  logic             granted_q;   // any grant since reset; selects first-tie rule
  logic             lat_we_q;
  logic [W_CPU-1:0] lat_addr_q;
  logic [W_CPU-1:0] lat_wdata_q;
  logic [W_CPU-1:0] i_rdata_q;
  logic [W_CPU-1:0] d_rdata_q;
  logic             i_done_q;
  logic             d_done_q;

  logic idle;
  logic fetch_wins;

  always_comb begin
    // Grants are suppressed while reset is asserted so no access starts then.
    idle       = (state_q == StIdle) && rst;
    fetch_wins = i_req && (!d_req || !granted_q || owner_q);
    i_gnt      = idle && fetch_wins;
    d_gnt      = idle && d_req && !fetch_wins;
    m_en       = i_gnt || d_gnt;

    if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_gnt) begin
      m_we    = 1'b0;
      m_addr  = i_addr;
      m_wdata = '0;
    end else begin
      m_we    = (state_q == StWait) ? lat_we_q : 1'b0;
      m_addr  = lat_addr_q;
      m_wdata = lat_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      granted_q   <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (m_en) begin
            lat_we_q    <= m_we;
            lat_addr_q  <= m_addr;
            lat_wdata_q <= m_wdata;
            owner_q     <= d_gnt;
            granted_q   <= 1'b1;
            cnt_q       <= 4'd1;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == LatC) begin
            if (owner_q) begin
              d_done_q <= 1'b1;
              if (!lat_we_q) d_rdata_q <= m_rdata;
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= m_rdata;
            end
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q == StWait);
  assign owner   = owner_q;

endmodule
